gui_sprite_compositor: RTL and testbench
========================================

Name: gui_sprite_compositor

Overview:
Sits between the OLED driver's pixel scan and the full-screen GUI sprite ROMs (pixel_index in, RGB565 out).
- Translates each scanned pixel into an offset ROM index so sprites can be moved on screen.
- Selects the animation frame ROM.
- Keys out black pixels as transparent over a background colour.
- Registers the result for the OLED driver.

Parameters:
- WIDTH, 96: screen width in pixels.
- HEIGHT, 64: screen height in pixels.
- NUM_FRAMES, 4: number of animation frame ROMs (2..4).
- FRAME_HOLD, 6: OLED frames each animation frame is shown.
- KEY_COLOUR, 16'h0000: ROM colour treated as transparent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_begin  in  1  one-cycle strobe at start of each OLED frame
- sample_pixel  in  1  one-cycle strobe: pixel_index is valid
- pixel_index  in  13  scanned pixel, row-major, 0..WIDTH*HEIGHT-1
- offset_x  in  7  sprite x displacement, 0..WIDTH-1
- offset_y  in  6  sprite y displacement, 0..HEIGHT-1
- anim_start  in  1  pulse: start animation from frame 0
- anim_loop  in  1  1 = loop animation, 0 = one-shot
- bg_colour  in  16  background RGB565
- rom_index  out  13  index to the selected sprite ROM
- frame_sel  out  2  which frame ROM drives rom_colour
- rom_colour  in  16  combinational ROM data for rom_index/frame_sel
- oled_data  out  16  composited RGB565 pixel
- pixel_valid  out  1  oled_data updated this cycle
- anim_busy  out  1  animation in PLAY

Behaviour:
Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Reset values:
- rom_index=0, frame_sel=0, oled_data=0, pixel_valid=0, anim_busy=0.
- Latched offsets=0; FSM in IDLE; hold counter=0.

Offset latching:
- offset_x/offset_y are captured only on frame_begin. A mid-frame change takes effect from the next frame, so there is no tearing.

Stage 1 (cycle after sample_pixel):
- Compute sx = pixel_index mod WIDTH and sy = pixel_index div WIDTH by constant divide.
- Compute rx = sx - off_x and ry = sy - off_y, 8-bit signed.
- in_range = rx>=0 && rx<WIDTH && ry>=0 && ry<HEIGHT.
- Register rom_index = ry*WIDTH+rx when in_range, else 0.
- Register in_range and frame_sel with the index.
- pixel_index >= WIDTH*HEIGHT is treated as out of range.

Stage 2:
- oled_data = (in_range_q && rom_colour != KEY_COLOUR) ? rom_colour : bg_colour.
- pixel_valid pulses in the same cycle.
- Latency: sample_pixel at cycle N gives pixel_valid at N+2.
- Back-to-back samples every cycle are supported; the pipeline never stalls.

Animation FSM:
- IDLE: frame_sel=0, anim_busy=0. anim_start → PLAY with frame_sel=0, hold=0.
- PLAY: anim_busy=1. Each frame_begin increments hold. At hold==FRAME_HOLD-1, hold=0 and frame_sel advances.
  - Advancing past NUM_FRAMES-1 with anim_loop=1 wraps to 0.
  - With anim_loop=0 it goes to IDLE, frame_sel=0.
- anim_start while in PLAY restarts at frame 0, hold=0. anim_start wins over a simultaneous advance or wrap.
- frame_sel changes only on frame_begin, so there are no mid-frame frame switches. The exception is anim_start, which applies immediately.

Reset mid-operation: all state returns to reset values asynchronously, and the pipeline contents are discarded.

Optional Feature:
Macro GUI_MIRROR_EN.
- Defined: adds input port mirror (1 bit), latched on frame_begin like the offsets. When set, the horizontal ROM coordinate becomes WIDTH-1-rx; the in_range test is unchanged.
- Undefined: no mirror port; rx is used directly.

Decomposition:
Shared package gui_pkg holds:
- RGB565 width constant (16);
- SCREEN_W=96, SCREEN_H=64, PIX_IDX_W=13;
- the anim_state enum (IDLE, PLAY);
- the default KEY_COLOUR.

One natural sub-module, gui_anim_seq: the FSM plus hold counter producing frame_sel and anim_busy. The pixel pipeline stays in the top.

Test Plan:
- Offsets 0,0; pixel_index=1871 sampled; rom_colour=16'hFFDF → rom_index=1871 at N+1; oled_data=16'hFFDF, pixel_valid=1 at N+2.
- offset_x=10, offset_y=2 latched on frame_begin; pixel_index=2*96+10=202 → rom_index=0, in_range=1; pixel_index=201 (sx=9) → out of range, oled_data=bg_colour=16'h001F.
- rom_colour=16'h0000 while in range → oled_data=bg_colour. A change to offset_x mid-frame → no change to rom_index until the next frame_begin.
- anim_start, anim_loop=0, FRAME_HOLD=6, NUM_FRAMES=4 → frame_sel 0→1→2→3 after each 6 frame_begins; after the 24th frame_begin → IDLE, anim_busy=0, frame_sel=0. With anim_loop=1 it wraps to 0 and anim_busy stays 1.
- anim_start in the same cycle as a frame_sel advance → frame_sel=0, hold=0.
- rst_n asserted mid-stream, mid-animation → all outputs 0 asynchronously. After release, the next sample yields pixel_valid only 2 cycles later.

Source files
------------

// File: rtl/gui_pkg.sv
// gui_pkg: shared screen geometry, colour width and animation state type for the GUI sprite path.
package gui_pkg;
    localparam int RGB_W = 16;
    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int PIX_IDX_W = 13;
    localparam logic [RGB_W-1:0] KEY_COLOUR_DEF = 16'h0000;
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} anim_state_t;
endpackage

// File: rtl/gui_anim_seq.sv
// gui_anim_seq: animation sequencer; advances frame_sel every FRAME_HOLD OLED frames, one-shot or looping.
module gui_anim_seq
    import gui_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_begin,
    input  logic       anim_start,
    input  logic       anim_loop,
    output logic [1:0] frame_sel,
    output logic       anim_busy
);
    localparam int HW = FRAME_HOLD > 1 ? $clog2(FRAME_HOLD) : 1;
    anim_state_t state;
    logic [HW-1:0] hold;
    assign anim_busy = state == PLAY;
    // anim_start has priority so a restart always lands on frame 0 with a fresh hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            frame_sel <= '0;
            hold <= '0;
        end else if (anim_start) begin
            state <= PLAY;
            frame_sel <= '0;
            hold <= '0;
        end else if (state == PLAY && frame_begin) begin
            if (hold == HW'(FRAME_HOLD - 1)) begin
                hold <= '0;
                if (frame_sel == 2'(NUM_FRAMES - 1)) begin
                    frame_sel <= '0;
                    if (!anim_loop) state <= IDLE;
                end else begin
                    frame_sel <= frame_sel + 2'd1;
                end
            end else begin
                hold <= hold + HW'(1);
            end
        end
    end
endmodule

// File: rtl/gui_sprite_compositor.sv
// gui_sprite_compositor: offsets scanned pixels into sprite ROM space, keys out KEY_COLOUR over bg_colour.
// Defining GUI_MIRROR_EN adds a per-frame horizontal mirror input.
module gui_sprite_compositor
    import gui_pkg::*;
#(
    parameter int WIDTH = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter logic [15:0] KEY_COLOUR = KEY_COLOUR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_begin,
    input  logic        sample_pixel,
    input  logic [12:0] pixel_index,
    input  logic [6:0]  offset_x,
    input  logic [5:0]  offset_y,
`ifdef GUI_MIRROR_EN
    input  logic        mirror,
`endif
    input  logic        anim_start,
    input  logic        anim_loop,
    input  logic [15:0] bg_colour,
    output logic [12:0] rom_index,
    output logic [1:0]  frame_sel,
    input  logic [15:0] rom_colour,
    output logic [15:0] oled_data,
    output logic        pixel_valid,
    output logic        anim_busy
);
    logic [6:0] off_x, sx, sy, col;
    logic [5:0] off_y;
    logic [7:0] rx, ry;
    logic in_range, in_range_q, valid_q;
`ifdef GUI_MIRROR_EN
    logic mirror_q;
`endif

    gui_anim_seq #(.NUM_FRAMES(NUM_FRAMES), .FRAME_HOLD(FRAME_HOLD)) u_seq (
        .clk(clk),
        .rst_n(rst_n),
        .frame_begin(frame_begin),
        .anim_start(anim_start),
        .anim_loop(anim_loop),
        .frame_sel(frame_sel),
        .anim_busy(anim_busy)
    );

    // rx/ry are 8-bit two's complement; bit 7 set means left of / above the sprite origin
    assign sx = 7'(pixel_index % 13'(WIDTH));
    assign sy = 7'(pixel_index / 13'(WIDTH));
    assign rx = {1'b0, sx} - {1'b0, off_x};
    assign ry = {1'b0, sy} - {2'b0, off_y};
    assign in_range = pixel_index < 13'(WIDTH * HEIGHT) && !rx[7] && !ry[7]
                      && rx[6:0] < 7'(WIDTH) && ry[6:0] < 7'(HEIGHT);
`ifdef GUI_MIRROR_EN
    assign col = mirror_q ? 7'(WIDTH - 1) - rx[6:0] : rx[6:0];
`else
    assign col = rx[6:0];
`endif

    // geometry only changes at frame start so a frame is never torn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_x <= '0;
            off_y <= '0;
`ifdef GUI_MIRROR_EN
            mirror_q <= 1'b0;
`endif
        end else if (frame_begin) begin
            off_x <= offset_x;
            off_y <= offset_y;
`ifdef GUI_MIRROR_EN
            mirror_q <= mirror;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_index <= '0;
            in_range_q <= 1'b0;
            valid_q <= 1'b0;
            oled_data <= '0;
            pixel_valid <= 1'b0;
        end else begin
            valid_q <= sample_pixel;
            pixel_valid <= valid_q;
            if (sample_pixel) begin
                rom_index <= in_range ? 13'(ry[6:0]) * 13'(WIDTH) + 13'(col) : '0;
                in_range_q <= in_range;
            end
            if (valid_q)
                oled_data <= (in_range_q && rom_colour != KEY_COLOUR) ? rom_colour : bg_colour;
        end
    end
endmodule

// File: tb/tb_gui_sprite_compositor.sv
// tb_gui_sprite_compositor: directed checks of offset mapping, keying, latency, animation and async reset.
module tb_gui_sprite_compositor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_begin = 1'b0;
    logic        sample_pixel = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [6:0]  offset_x = '0;
    logic [5:0]  offset_y = '0;
    logic        anim_start = 1'b0;
    logic        anim_loop = 1'b0;
    logic [15:0] bg_colour = 16'h001F;
    logic [12:0] rom_index;
    logic [1:0]  frame_sel;
    logic [15:0] rom_colour;
    logic [15:0] oled_data;
    logic        pixel_valid;
    logic        anim_busy;
    logic        rom_force = 1'b0;
    logic [15:0] rom_val = '0;
    int n_cmp = 0;
    int n_err = 0;

    gui_sprite_compositor dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_begin(frame_begin),
        .sample_pixel(sample_pixel),
        .pixel_index(pixel_index),
        .offset_x(offset_x),
        .offset_y(offset_y),
        .anim_start(anim_start),
        .anim_loop(anim_loop),
        .bg_colour(bg_colour),
        .rom_index(rom_index),
        .frame_sel(frame_sel),
        .rom_colour(rom_colour),
        .oled_data(oled_data),
        .pixel_valid(pixel_valid),
        .anim_busy(anim_busy)
    );

    always #5 clk = ~clk;

    // ROM model: colour encodes frame and index so routing errors are visible
    always_comb rom_colour = rom_force ? rom_val : {1'b1, frame_sel, rom_index};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fb();
        frame_begin = 1'b1;
        cyc();
        frame_begin = 1'b0;
    endtask

    task automatic samp(input logic [12:0] idx);
        pixel_index = idx;
        sample_pixel = 1'b1;
        cyc();
        sample_pixel = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_rom_index", rom_index, 0);
        chk("rst_frame_sel", frame_sel, 0);
        chk("rst_oled", oled_data, 0);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_busy", anim_busy, 0);
        #2 rst_n = 1'b1;
        cyc();
        rom_force = 1'b1;
        rom_val = 16'hFFDF;
        samp(13'd1871);
        chk("s1_index", rom_index, 1871);
        chk("s1_valid_early", pixel_valid, 0);
        cyc();
        chk("s1_valid", pixel_valid, 1);
        chk("s1_oled", oled_data, 16'hFFDF);
        cyc();
        chk("s1_valid_drop", pixel_valid, 0);
        offset_x = 7'd10;
        offset_y = 6'd2;
        fb();
        rom_val = 16'h1234;
        samp(13'd202);
        chk("off_origin_index", rom_index, 0);
        cyc();
        chk("off_origin_oled", oled_data, 16'h1234);
        samp(13'd201);
        chk("off_left_index", rom_index, 0);
        cyc();
        chk("off_left_oled", oled_data, 16'h001F);
        samp(13'd300);
        chk("off_300_index", rom_index, 98);
        rom_val = 16'h0000;
        cyc();
        chk("key_oled", oled_data, 16'h001F);
        offset_x = 7'd20;
        samp(13'd300);
        chk("midframe_index", rom_index, 98);
        fb();
        samp(13'd2000);
        chk("newframe_index", rom_index, 1788);
        offset_x = 7'd0;
        offset_y = 6'd0;
        fb();
        rom_force = 1'b0;
        samp(13'd6143);
        chk("last_index", rom_index, 6143);
        cyc();
        chk("last_oled", oled_data, 16'h97FF);
        samp(13'd6144);
        chk("beyond_index", rom_index, 0);
        cyc();
        chk("beyond_oled", oled_data, 16'h001F);
        pixel_index = 13'd100;
        sample_pixel = 1'b1;
        cyc();
        chk("b2b_index0", rom_index, 100);
        chk("b2b_valid0", pixel_valid, 0);
        pixel_index = 13'd101;
        cyc();
        sample_pixel = 1'b0;
        chk("b2b_index1", rom_index, 101);
        chk("b2b_valid1", pixel_valid, 1);
        chk("b2b_oled1", oled_data, 16'h8064);
        cyc();
        chk("b2b_valid2", pixel_valid, 1);
        chk("b2b_oled2", oled_data, 16'h8065);
        cyc();
        chk("b2b_valid3", pixel_valid, 0);
        anim_loop = 1'b0;
        anim_start = 1'b1;
        cyc();
        anim_start = 1'b0;
        chk("os_start_busy", anim_busy, 1);
        chk("os_start_frame", frame_sel, 0);
        for (int i = 1; i <= 24; i++) begin
            fb();
            chk($sformatf("os_frame_%0d", i), frame_sel, i < 24 ? i / 6 : 0);
            chk($sformatf("os_busy_%0d", i), anim_busy, i < 24 ? 1 : 0);
        end
        anim_loop = 1'b1;
        anim_start = 1'b1;
        cyc();
        anim_start = 1'b0;
        for (int i = 1; i <= 30; i++) fb();
        chk("loop_frame", frame_sel, 1);
        chk("loop_busy", anim_busy, 1);
        samp(13'd5);
        cyc();
        chk("loop_oled_frame", oled_data, 16'hA005);
        anim_start = 1'b1;
        cyc();
        anim_start = 1'b0;
        chk("restart_frame", frame_sel, 0);
        for (int i = 1; i <= 5; i++) fb();
        anim_start = 1'b1;
        fb();
        anim_start = 1'b0;
        chk("tie_frame", frame_sel, 0);
        for (int i = 1; i <= 5; i++) fb();
        chk("tie_hold_frame", frame_sel, 0);
        fb();
        chk("tie_advance_frame", frame_sel, 1);
        offset_x = 7'd10;
        offset_y = 6'd2;
        fb();
        samp(13'd1871);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rom_index", rom_index, 0);
        chk("arst_frame_sel", frame_sel, 0);
        chk("arst_oled", oled_data, 0);
        chk("arst_valid", pixel_valid, 0);
        chk("arst_busy", anim_busy, 0);
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", pixel_valid, 0);
        samp(13'd1871);
        chk("post_rst_index", rom_index, 1871);
        chk("post_rst_valid1", pixel_valid, 0);
        cyc();
        chk("post_rst_valid2", pixel_valid, 1);
        chk("post_rst_oled", oled_data, 16'h874F);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
